// File: rtl/csa_sched_pkg.sv
// csa_sched_pkg: shared definitions for the two-requester adder scheduler.
//   - state_t    : scheduler FSM encoding (IDLE, LOW, HIGH, RESP)
//   - DEF_WIDTH  : default adder datapath width
//   - DEF_CNT_W  : default completion counter width
//   - REQ0/REQ1  : requester id values carried on rsp_id
package csa_sched_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/add_cin_w.sv
// add_cin_w: combinational WIDTH-bit carry-select adder with carry-in.
// Ports:
//   a, b  : WIDTH-bit operands
//   cin   : carry in
//   sum   : WIDTH-bit sum
//   cout  : carry out of the top bit
// WIDTH must be a multiple of 4 (one carry-select block per nibble).
module add_cin_w #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NBLK = WIDTH / 4;

  // Block carries: c[gi] enters nibble gi, c[NBLK] is the final carry.
  logic [NBLK:0] c;

  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < NBLK; gi++) begin : g_blk
      logic [4:0] s0;
      logic [4:0] s1;
      // Both candidate sums are formed up front; the incoming carry only
      // drives a mux, which keeps the ripple path to one mux per nibble.
      assign s0 = {1'b0, a[gi*4 +: 4]} + {1'b0, b[gi*4 +: 4]};
      assign s1 = {1'b0, a[gi*4 +: 4]} + {1'b0, b[gi*4 +: 4]} + 5'd1;
      assign sum[gi*4 +: 4] = c[gi] ? s1[3:0] : s0[3:0];
      assign c[gi+1]        = c[gi] ? s1[4]   : s0[4];
    end
  endgenerate

  assign cout = c[NBLK];

endmodule

// File: rtl/csa_add_scheduler.sv
// csa_add_scheduler: round-robin scheduler sharing one WIDTH-bit adder
// between two requesters. Narrow requests take one adder pass, wide
// requests take two with the low-pass carry chained into the high pass.
// Ports:
//   clock, reset            : clock, asynchronous active-low reset
//   reqN_valid/ready        : request handshake (ready is combinational)
//   reqN_wide               : 1 = 2*WIDTH add, 0 = WIDTH add
//   reqN_a, reqN_b          : operands (narrow uses low WIDTH bits only)
//   rsp_valid/ready         : result handshake
//   rsp_id, rsp_sum, rsp_cout : result owner, sum and carry out
//   done_cnt0, done_cnt1    : wrapping per-requester completion counters
module csa_add_scheduler
  import csa_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_wide,
  input  logic [2*WIDTH-1:0] req0_a,
  input  logic [2*WIDTH-1:0] req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_wide,
  input  logic [2*WIDTH-1:0] req1_a,
  input  logic [2*WIDTH-1:0] req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_sum,
  output logic               rsp_cout,
  output logic [CNT_W-1:0]   done_cnt0,
  output logic [CNT_W-1:0]   done_cnt1
);

  state_t             state_reg, state_next;
  logic               rr_ptr_reg;
  logic [2*WIDTH-1:0] a_reg, b_reg;
  logic               wide_reg, id_reg;
  logic               carry_lo_reg, cout_reg;
  logic [WIDTH-1:0]   sum_lo_reg, sum_hi_reg;

  logic [1:0]         valid_vec;
  logic               grant_any, grant_id;
  logic               complete;

  logic [WIDTH-1:0]   add_a, add_b, add_sum;
  logic               add_cin, add_cout;

  logic [1:0][CNT_W-1:0] done_cnt_vec;

  assign valid_vec = {req1_valid, req0_valid};
  assign complete  = (state_reg == RESP) && rsp_ready;

  // Arbitration: favour rr_ptr, fall back to the other requester so a
  // lone requester is never stalled by the pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = rr_ptr_reg;
    if (state_reg == IDLE) begin
      if (valid_vec[rr_ptr_reg]) begin
        grant_any = 1'b1;
        grant_id  = rr_ptr_reg;
      end else if (valid_vec[!rr_ptr_reg]) begin
        grant_any = 1'b1;
        grant_id  = !rr_ptr_reg;
      end
    end
  end

  assign req0_ready = grant_any && (grant_id == REQ0);
  assign req1_ready = grant_any && (grant_id == REQ1);

  // Single adder; its operand halves and carry-in follow the pass.
  assign add_a   = (state_reg == HIGH) ? a_reg[2*WIDTH-1:WIDTH] : a_reg[WIDTH-1:0];
  assign add_b   = (state_reg == HIGH) ? b_reg[2*WIDTH-1:WIDTH] : b_reg[WIDTH-1:0];
  assign add_cin = (state_reg == HIGH) && carry_lo_reg;

  add_cin_w #(.WIDTH(WIDTH)) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = LOW;
      LOW:     state_next = wide_reg ? HIGH : RESP;
      HIGH:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= REQ0;
      a_reg        <= '0;
      b_reg        <= '0;
      wide_reg     <= 1'b0;
      id_reg       <= REQ0;
      carry_lo_reg <= 1'b0;
      cout_reg     <= 1'b0;
      sum_lo_reg   <= '0;
      sum_hi_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            a_reg    <= grant_id ? req1_a : req0_a;
            b_reg    <= grant_id ? req1_b : req0_b;
            wide_reg <= grant_id ? req1_wide : req0_wide;
            id_reg   <= grant_id;
          end
        end
        LOW: begin
          sum_lo_reg   <= add_sum;
          carry_lo_reg <= add_cout;
          // Narrow results finish here: upper half zero, carry is final.
          sum_hi_reg   <= '0;
          cout_reg     <= add_cout;
        end
        HIGH: begin
          sum_hi_reg <= add_sum;
          cout_reg   <= add_cout;
        end
        RESP: begin
          if (rsp_ready) rr_ptr_reg <= !id_reg;
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (complete && (id_reg == 1'(gi))) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
      assign done_cnt_vec[gi] = cnt_reg;
    end
  endgenerate

  assign done_cnt0 = done_cnt_vec[0];
  assign done_cnt1 = done_cnt_vec[1];

  assign rsp_valid = (state_reg == RESP);
  assign rsp_id    = id_reg;
  assign rsp_sum   = {sum_hi_reg, sum_lo_reg};
  assign rsp_cout  = cout_reg;

endmodule

// File: tb/tb_csa_add_scheduler.sv
// tb_csa_add_scheduler: self-checking bench for csa_add_scheduler.
// Expected results are pushed to a scoreboard queue at each request
// handshake and compared as responses are accepted; directed checks cover
// reset, latency, carry chaining, arbitration, backpressure and mid-op reset.
module tb_csa_add_scheduler;

  localparam int W  = 64;
  localparam int CW = 16;

  typedef struct packed {
    logic         id;
    logic [127:0] sum;
    logic         cout;
  } exp_t;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           req0_valid = 1'b0, req0_wide = 1'b0;
  logic [127:0]   req0_a = '0, req0_b = '0;
  logic           req1_valid = 1'b0, req1_wide = 1'b0;
  logic [127:0]   req1_a = '0, req1_b = '0;
  logic           req0_ready, req1_ready;
  logic           rsp_valid, rsp_id, rsp_cout;
  logic           rsp_ready = 1'b1;
  logic [127:0]   rsp_sum;
  logic [CW-1:0]  done_cnt0, done_cnt1;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  csa_add_scheduler #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_wide  (req0_wide),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_wide  (req1_wide),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .done_cnt0  (done_cnt0),
    .done_cnt1  (done_cnt1)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input logic wide,
                                 input logic [127:0] a, input logic [127:0] b);
    exp_t e;
    logic [128:0] full;
    logic [64:0]  nar;
    e.id = id;
    if (wide) begin
      full   = {1'b0, a} + {1'b0, b};
      e.sum  = full[127:0];
      e.cout = full[128];
    end else begin
      nar    = {1'b0, a[63:0]} + {1'b0, b[63:0]};
      e.sum  = {64'd0, nar[63:0]};
      e.cout = nar[64];
    end
    return e;
  endfunction

  // Scoreboard monitor: push at request handshake, pop at response handshake.
  always @(negedge clock) begin
    if (reset) begin
      if (req0_ready || req1_ready) check("one_ready", req0_ready & req1_ready, 0);
      if (req0_valid && req0_ready) exp_q.push_back(model(1'b0, req0_wide, req0_a, req0_b));
      if (req1_valid && req1_ready) exp_q.push_back(model(1'b1, req1_wide, req1_a, req1_b));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_rsp", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          $display("rsp id=%0d sum=%0h cout=%0d", rsp_id, rsp_sum, rsp_cout);
          check("sb_id", rsp_id, mon_e.id);
          check("sb_sum", rsp_sum, mon_e.sum);
          check("sb_cout", rsp_cout, mon_e.cout);
        end
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic id, input logic wide, input logic [127:0] a,
                       input logic [127:0] b, input logic v);
    if (id == 1'b0) begin
      req0_valid = v; req0_wide = wide; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_wide = wide; req1_a = a; req1_b = b;
    end
  endtask

  task automatic apply_reset();
    exp_q.delete();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    reset      = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // Called just after a posedge; returns at the negedge where ready is seen.
  task automatic wait_grant(input logic id, output int cyc);
    cyc = 0;
    @(negedge clock);
    while (!(id ? req1_ready : req0_ready) && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("grant_seen", id ? req1_ready : req0_ready, 1);
  endtask

  // Issue one request and return at the first negedge with rsp_valid high.
  task automatic issue(input logic id, input logic wide, input logic [127:0] a,
                       input logic [127:0] b, input int exp_lat, output int gw,
                       output logic got_id, output logic [127:0] got_sum, output logic got_cout);
    int lat;
    drive(id, wide, a, b, 1'b1);
    wait_grant(id, gw);
    @(posedge clock);
    #1 drive(id, wide, a, b, 1'b0);
    lat = 1;
    @(negedge clock);
    while (!rsp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("latency", lat, exp_lat);
    got_id   = rsp_id;
    got_sum  = rsp_sum;
    got_cout = rsp_cout;
  endtask

  // Wait for the current/next response to be accepted; ends at posedge+1.
  task automatic wait_done();
    int cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clock);
      #1 cyc++;
    end
    do begin
      @(posedge clock);
      #1 cyc++;
    end while (rsp_valid && cyc < 40);
    check("rsp_drain", rsp_valid, 0);
  endtask

  initial begin
    int           gw, ng, cyc, c0, c1;
    logic         g0, g1, gid, gcout;
    logic [127:0] gsum, held_sum;
    logic [7:0]   order;
    logic         rid, rwide;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_cnt0", done_cnt0, 0);
    check("rst_cnt1", done_cnt1, 0);
    @(posedge clock);
    #1 reset = 1'b1;

    // 1. Narrow overflow
    issue(1'b0, 1'b0, 128'hFFFFFFFFFFFFFFFF, 128'h1, 2, gw, gid, gsum, gcout);
    check("t1_ready_first", gw, 0);
    check("t1_sum", gsum, 0);
    check("t1_cout", gcout, 1);
    check("t1_id", gid, 0);
    wait_done();
    check("t1_cnt0", done_cnt0, 1);

    // 2. Wide carry chain
    issue(1'b1, 1'b1, {64'h1, 64'hFFFFFFFFFFFFFFFF}, {64'h0, 64'h1}, 3, gw, gid, gsum, gcout);
    check("t2_sum", gsum, {64'h2, 64'h0});
    check("t2_cout", gcout, 0);
    check("t2_id", gid, 1);
    wait_done();
    check("t2_cnt1", done_cnt1, 1);

    // 3. Wide full overflow, then narrow with junk upper operand bits
    issue(1'b0, 1'b1, {128{1'b1}}, 128'h1, 3, gw, gid, gsum, gcout);
    check("t3w_sum", gsum, 0);
    check("t3w_cout", gcout, 1);
    wait_done();
    issue(1'b1, 1'b0, {64'hDEADBEEFCAFEF00D, 64'hFFFFFFFFFFFFFFFF},
          {64'h8000000000000001, 64'h1}, 2, gw, gid, gsum, gcout);
    check("t3n_sum", gsum, 0);
    check("t3n_cout", gcout, 1);
    wait_done();
    issue(1'b0, 1'b0, {64'hABCDABCDABCDABCD, 64'h0123456789ABCDEF},
          {64'hFFFFFFFFFFFFFFFF, 64'h1111111111111111}, 2, gw, gid, gsum, gcout);
    check("t3n2_sum", gsum, {64'h0, 64'h123456789ABCDF00});
    check("t3n2_cout", gcout, 0);
    wait_done();

    // Random mix through the scoreboard
    for (int i = 0; i < 8; i++) begin
      rid   = 1'($urandom_range(0, 1));
      rwide = 1'($urandom_range(0, 1));
      issue(rid, rwide, rnd128(), rnd128(), rwide ? 3 : 2, gw, gid, gsum, gcout);
      wait_done();
    end

    // 4. Arbitration with both requesters continuously valid
    apply_reset();
    c0 = 0; c1 = 0; ng = 0; cyc = 0; order = '0;
    drive(1'b0, 1'b0, rnd128(), rnd128(), 1'b1);
    drive(1'b1, 1'b0, rnd128(), rnd128(), 1'b1);
    while ((c0 < 4 || c1 < 4) && cyc < 400) begin
      @(negedge clock);
      g0 = req0_ready;
      g1 = req1_ready;
      @(posedge clock);
      #1;
      if (g0) begin
        if (ng < 8) order[ng] = 1'b0;
        ng++; c0++;
        drive(1'b0, 1'b0, rnd128(), rnd128(), c0 < 4);
      end
      if (g1) begin
        if (ng < 8) order[ng] = 1'b1;
        ng++; c1++;
        drive(1'b1, 1'b0, rnd128(), rnd128(), c1 < 4);
      end
      cyc++;
    end
    check("t4_no_timeout", cyc < 400, 1);
    wait_done();
    check("t4_grants", ng, 8);
    check("t4_order", order, 8'b10101010);
    check("t4_cnt0", done_cnt0, 4);
    check("t4_cnt1", done_cnt1, 4);

    // 5. Backpressure: hold the response for 5 cycles
    rsp_ready = 1'b0;
    issue(1'b0, 1'b0, 128'h5555, 128'h7777, 2, gw, gid, gsum, gcout);
    held_sum = gsum;
    check("t5_sum", held_sum, 128'hCCCC);
    @(posedge clock);
    #1 drive(1'b1, 1'b0, 128'h10, 128'h20, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t5_hold_valid", rsp_valid, 1);
      check("t5_hold_sum", rsp_sum, held_sum);
      check("t5_hold_id", rsp_id, 0);
      check("t5_no_ready0", req0_ready, 0);
      check("t5_no_ready1", req1_ready, 0);
      check("t5_hold_cnt0", done_cnt0, 4);
    end
    @(posedge clock);
    #1 rsp_ready = 1'b1;
    @(negedge clock);
    check("t5_still_valid", rsp_valid, 1);
    @(posedge clock);
    #1;
    check("t5_done_cnt0", done_cnt0, 5);
    check("t5_released", rsp_valid, 0);
    wait_grant(1'b1, gw);
    @(posedge clock);
    #1 drive(1'b1, 1'b0, 128'h10, 128'h20, 1'b0);
    wait_done();
    check("t5_done_cnt1", done_cnt1, 5);

    // 6. Reset in the HIGH pass of a wide request
    apply_reset();
    drive(1'b1, 1'b1, 128'h1234, 128'h5678, 1'b1);
    wait_grant(1'b1, gw);
    @(posedge clock);
    #1 drive(1'b1, 1'b1, 128'h1234, 128'h5678, 1'b0);
    @(posedge clock);
    #1;
    check("t6_pre_sum", rsp_sum, 128'h68AC);
    exp_q.delete();
    reset = 1'b0;
    #1;
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_rsp_sum", rsp_sum, 0);
    check("t6_rsp_cout", rsp_cout, 0);
    check("t6_rsp_id", rsp_id, 0);
    check("t6_cnt0", done_cnt0, 0);
    check("t6_cnt1", done_cnt1, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    drive(1'b1, 1'b0, 128'h3, 128'h4, 1'b1);
    @(negedge clock);
    check("t6_lone1_ready", req1_ready, 1);
    check("t6_lone1_r0", req0_ready, 0);
    @(posedge clock);
    #1 drive(1'b1, 1'b0, 128'h3, 128'h4, 1'b0);
    wait_done();
    drive(1'b0, 1'b0, 128'h9, 128'h1, 1'b1);
    drive(1'b1, 1'b0, 128'h8, 128'h2, 1'b1);
    @(negedge clock);
    check("t6_both_r0", req0_ready, 1);
    check("t6_both_r1", req1_ready, 0);
    @(posedge clock);
    #1 drive(1'b0, 1'b0, 128'h9, 128'h1, 1'b0);
    wait_grant(1'b1, gw);
    @(posedge clock);
    #1 drive(1'b1, 1'b0, 128'h8, 128'h2, 1'b0);
    wait_done();
    check("t6_end_cnt0", done_cnt0, 1);
    check("t6_end_cnt1", done_cnt1, 2);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/csa_add_scheduler.md
Name: csa_add_scheduler

Overview:
- Two-requester round-robin scheduler that shares one WIDTH-bit adder datapath between two clients.
- Each request is either a narrow add (WIDTH bits, one adder pass) or a wide add (2*WIDTH bits, two passes with the carry chained from the low pass into the high pass).
- Sits between client logic and the adder datapath.
- Owns operand capture, pass sequencing, carry chaining, the result handshake and per-client completion counters.

Parameters:
- WIDTH, 64, adder datapath width in bits; operand and result buses are 2*WIDTH.
- CNT_W, 16, width of the per-requester completion counters.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_wide  input  1  1 = 2*WIDTH add, 0 = WIDTH add.
- req0_a  input  2*WIDTH  operand A; narrow requests use bits [WIDTH-1:0] only.
- req0_b  input  2*WIDTH  operand B; narrow requests use bits [WIDTH-1:0] only.
- req1_valid, req1_ready, req1_wide, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  requester that owns the result.
- rsp_sum  output  2*WIDTH  sum; upper WIDTH bits are 0 for narrow requests.
- rsp_cout  output  1  carry out of the top pass.
- done_cnt0  output  CNT_W  completed responses for requester 0 (wraps).
- done_cnt1  output  CNT_W  completed responses for requester 1 (wraps).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0 (requester 0 has priority).
  - Operand, carry and result registers cleared to 0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, done_cnt0=done_cnt1=0.
  - An in-flight transaction is dropped silently.
- State machine: IDLE, LOW, HIGH, RESP.
- IDLE:
  - grant = requester rr_ptr if its valid is high, else the other requester if its valid is high.
  - reqN_ready = (state==IDLE) && grant==N. This is combinational from valid; at most one ready is high per cycle.
  - On the handshake edge: capture a, b, wide and id, then go to LOW.
  - No valid: stay in IDLE.
- LOW:
  - Adder computes a[W-1:0] + b[W-1:0] with cin=0.
  - Register sum_lo and carry_lo.
  - wide=1: go to HIGH.
  - wide=0: go to RESP with rsp_sum={0, sum_lo} and rsp_cout=carry_lo.
- HIGH:
  - Adder computes a[2W-1:W] + b[2W-1:W] with cin=carry_lo.
  - Register sum_hi and the carry; rsp_cout = carry out of this pass.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_sum and rsp_cout are stable while rsp_ready=0.
  - On rsp_valid && rsp_ready:
    - Increment done_cnt[id] with wrap at 2^CNT_W.
    - Set rr_ptr = ~id.
    - Go to IDLE; rsp_valid=0 on the next cycle.
- Latency from handshake edge to first cycle with rsp_valid high:
  - narrow: 2 edges;
  - wide: 3 edges.
- Throughput: one request in flight; no request is accepted during LOW, HIGH or RESP.
- Fairness:
  - With both requesters continuously valid, grants alternate 0,1,0,1...
  - A lone requester is granted back-to-back regardless of rr_ptr.
- Operand bits [2W-1:W] of a narrow request are ignored and never affect rsp_sum or rsp_cout.
- Arithmetic is unsigned modulo 2^(2W) for wide requests and 2^W for narrow; the overflow bit goes to rsp_cout.
- valid dropped by a requester before its ready: no capture, no side effect.

Decomposition:
- Shared package csa_sched_pkg:
  - state encoding constants (IDLE=2'd0, LOW=2'd1, HIGH=2'd2, RESP=2'd3);
  - WIDTH default;
  - requester id constants.
- One sub-module, add_cin_w:
  - combinational WIDTH-bit carry-select adder with carry-in, 4-bit blocks;
  - ports a, b, cin, sum, cout.
- The scheduler instantiates exactly one add_cin_w and multiplexes its operands by state.

Test Plan:
1. Narrow overflow: after reset, req0 narrow, a=0xFFFFFFFFFFFFFFFF, b=0x1, rsp_ready=1.
   - req0_ready on the first cycle; rsp_valid 2 edges later.
   - rsp_sum=0, rsp_cout=1, rsp_id=0, done_cnt0=1.
2. Wide carry chain: req1 wide, a={0x1, 0xFFFFFFFFFFFFFFFF}, b={0x0, 0x1}.
   - rsp_valid 3 edges after the handshake.
   - rsp_sum={0x2, 0x0}, rsp_cout=0, rsp_id=1.
3. Wide full overflow: a=all ones (128 bits), b=1.
   - rsp_sum=0, rsp_cout=1.
   - Same operands issued narrow with nonzero upper bits give rsp_sum upper half=0.
4. Arbitration: both requesters valid continuously from reset, 4 narrow requests each.
   - Grant order 0,1,0,1,...; never both ready in one cycle.
   - done_cnt0=done_cnt1=4.
5. Backpressure: rsp_ready=0 for 5 cycles in RESP.
   - rsp_valid, rsp_sum and rsp_id held stable; req0_ready and req1_ready stay 0.
   - Completion in the cycle rsp_ready rises.
6. Reset mid-operation: assert reset in HIGH of a wide request.
   - All outputs 0 immediately (asynchronous), state IDLE, counters unchanged from 0.
   - After release, a new req1 is granted over req0 only if req0 is not valid, because rr_ptr=0.
